// File: rtl/divider_pkg.sv
// Definitions shared by the divider and its inverse, remainder_multiply.
// Holds the operand width, the counter width and the handshake state encoding.
package divider_pkg;

    localparam int W     = 5;
    localparam int CW    = $clog2(W);
    localparam int ACC_W = 2 * W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/remainder_multiply_if.sv
// start/ok/err handshake and operand bus for remainder_multiply.
// The requester uses master; the block uses slave.
interface remainder_multiply_if;
    import divider_pkg::*;

    logic         start;
    logic [W-1:0] Q;
    logic [W-1:0] B;
    logic [W-1:0] R;
    logic [W-1:0] A;
    logic         ok;
    logic         err;

    modport master (output start, Q, B, R, input  A, ok, err);
    modport slave  (input  start, Q, B, R, output A, ok, err);

endinterface

// File: rtl/remainder_multiply.sv
// Rebuilds the dividend A = Q*B + R with a shift-add loop, one partial product per cycle.
// Uses the divider's four-phase start/ok/err handshake.
module remainder_multiply
    import divider_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    remainder_multiply_if.slave bus
);

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t             state;
    logic [W-1:0]       qreg;
    logic [W-1:0]       breg;
    logic [ACC_W-1:0]   acc;
    logic [CW-1:0]      count;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_next;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        addend   = '0;
        acc_next = acc;
        addend   = ACC_W'(breg) << count;
        if (qreg[count]) acc_next = acc + addend;
    end

    // NOTE: registered state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            qreg    <= '0;
            breg    <= '0;
            acc     <= '0;
            count   <= '0;
            bus.A   <= '0;
            bus.ok  <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.ok  <= 1'b0;
                    bus.err <= 1'b0;
                    if (bus.start) begin
                        qreg <= bus.Q;
                        breg <= bus.B;
                        // A remainder must be strictly below a nonzero divisor.
                        if (bus.B == '0 || bus.R >= bus.B) begin
                            state   <= DONE;
                            bus.err <= 1'b1;
                            bus.A   <= '0;
                        end else begin
                            acc   <= ACC_W'(bus.R);
                            count <= '0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                        // Any bit above W means the dividend cannot be represented.
                        if (|acc_next[ACC_W-1:W]) begin
                            bus.err <= 1'b1;
                            bus.A   <= '0;
                        end else begin
                            bus.ok <= 1'b1;
                            bus.A  <= acc_next[W-1:0];
                        end
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        state   <= IDLE;
                        bus.ok  <= 1'b0;
                        bus.err <= 1'b0;
                        bus.A   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_remainder_multiply.sv
// Directed bench for remainder_multiply: reset, results, error paths, latency, handshake.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_remainder_multiply;
    import divider_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    remainder_multiply_if bus ();

    remainder_multiply dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r);
        bus.Q     = q;
        bus.B     = b;
        bus.R     = r;
        bus.start = 1'b1;
        cycles(1);
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        cycles(1);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.Q     = '0;
        bus.B     = '0;
        bus.R     = '0;
        #20;
        checks++;
        if (bus.A !== '0 || bus.ok !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: A=%0d ok=%b err=%b, want A=0 ok=0 err=0", bus.A, bus.ok, bus.err);
        end
        cycles(2);
        reset = 1'b1;
        cycles(1);
    endtask

    task automatic test_basic_hold();
        launch(5'd2, 5'd10, 5'd2);
        // Scramble the operands after capture; the result must not move.
        bus.Q = 5'd31;
        bus.B = 5'd1;
        bus.R = 5'd0;
        cycles(4);
        checks++;
        if (bus.ok !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL basic_early: ok=%b err=%b after 4 run cycles, want ok=0 err=0", bus.ok, bus.err);
        end
        cycles(1);
        checks++;
        if (bus.ok !== 1'b1 || bus.err !== 1'b0 || bus.A !== 5'd22) begin
            failures++;
            $display("FAIL basic_result: A=%0d ok=%b err=%b, want A=22 ok=1 err=0", bus.A, bus.ok, bus.err);
        end
        cycles(8);
        checks++;
        if (bus.ok !== 1'b1 || bus.A !== 5'd22) begin
            failures++;
            $display("FAIL basic_hold: A=%0d ok=%b with start held, want A=22 ok=1", bus.A, bus.ok);
        end
        release_start();
        checks++;
        if (bus.ok !== 1'b0 || bus.A !== '0) begin
            failures++;
            $display("FAIL basic_release: A=%0d ok=%b, want A=0 ok=0", bus.A, bus.ok);
        end
    endtask

    task automatic test_zero_quotient();
        launch(5'd0, 5'd7, 5'd3);
        cycles(5);
        checks++;
        if (bus.ok !== 1'b1 || bus.err !== 1'b0 || bus.A !== 5'd3) begin
            failures++;
            $display("FAIL zero_q_result: A=%0d ok=%b err=%b, want A=3 ok=1 err=0", bus.A, bus.ok, bus.err);
        end
        release_start();
        checks++;
        if (bus.ok !== 1'b0 || bus.err !== 1'b0 || bus.A !== '0) begin
            failures++;
            $display("FAIL zero_q_release: A=%0d ok=%b err=%b, want all 0", bus.A, bus.ok, bus.err);
        end
    endtask

    task automatic test_bad_operands();
        launch(5'd4, 5'd0, 5'd0);
        checks++;
        if (bus.err !== 1'b1 || bus.ok !== 1'b0 || bus.A !== '0) begin
            failures++;
            $display("FAIL b_zero: A=%0d ok=%b err=%b, want A=0 ok=0 err=1", bus.A, bus.ok, bus.err);
        end
        cycles(3);
        checks++;
        if (bus.err !== 1'b1 || bus.ok !== 1'b0) begin
            failures++;
            $display("FAIL b_zero_hold: ok=%b err=%b, want ok=0 err=1", bus.ok, bus.err);
        end
        release_start();
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL b_zero_release: err=%b, want 0", bus.err);
        end
        launch(5'd1, 5'd10, 5'd10);
        checks++;
        if (bus.err !== 1'b1 || bus.ok !== 1'b0 || bus.A !== '0) begin
            failures++;
            $display("FAIL r_eq_b: A=%0d ok=%b err=%b, want A=0 ok=0 err=1", bus.A, bus.ok, bus.err);
        end
        release_start();
        // R one below B is legal: 1*10+9 = 19.
        launch(5'd1, 5'd10, 5'd9);
        checks++;
        if (bus.err !== 1'b0 || bus.ok !== 1'b0) begin
            failures++;
            $display("FAIL r_below_b_capture: ok=%b err=%b, want ok=0 err=0", bus.ok, bus.err);
        end
        cycles(5);
        checks++;
        if (bus.ok !== 1'b1 || bus.A !== 5'd19) begin
            failures++;
            $display("FAIL r_below_b_result: A=%0d ok=%b, want A=19 ok=1", bus.A, bus.ok);
        end
        release_start();
    endtask

    task automatic test_overflow_and_max();
        launch(5'd31, 5'd2, 5'd0);
        cycles(4);
        checks++;
        if (bus.err !== 1'b0 || bus.ok !== 1'b0) begin
            failures++;
            $display("FAIL overflow_early: ok=%b err=%b, want ok=0 err=0", bus.ok, bus.err);
        end
        cycles(1);
        checks++;
        if (bus.err !== 1'b1 || bus.ok !== 1'b0 || bus.A !== '0) begin
            failures++;
            $display("FAIL overflow: A=%0d ok=%b err=%b, want A=0 ok=0 err=1", bus.A, bus.ok, bus.err);
        end
        release_start();
        launch(5'd3, 5'd10, 5'd1);
        cycles(5);
        checks++;
        if (bus.ok !== 1'b1 || bus.err !== 1'b0 || bus.A !== 5'd31) begin
            failures++;
            $display("FAIL max_value: A=%0d ok=%b err=%b, want A=31 ok=1 err=0", bus.A, bus.ok, bus.err);
        end
        release_start();
        // Top quotient bit alone: 16*1+0 = 16.
        launch(5'd16, 5'd1, 5'd0);
        cycles(5);
        checks++;
        if (bus.ok !== 1'b1 || bus.A !== 5'd16) begin
            failures++;
            $display("FAIL top_bit: A=%0d ok=%b, want A=16 ok=1", bus.A, bus.ok);
        end
        release_start();
    endtask

    task automatic test_reset_abort();
        launch(5'd2, 5'd10, 5'd2);
        cycles(2);
        reset = 1'b0;
        #5;
        checks++;
        if (bus.ok !== 1'b0 || bus.err !== 1'b0 || bus.A !== '0) begin
            failures++;
            $display("FAIL reset_run: A=%0d ok=%b err=%b, want all 0", bus.A, bus.ok, bus.err);
        end
        bus.start = 1'b0;
        cycles(1);
        reset = 1'b1;
        cycles(7);
        checks++;
        if (bus.ok !== 1'b0 || bus.err !== 1'b0 || bus.A !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: A=%0d ok=%b err=%b, want all 0", bus.A, bus.ok, bus.err);
        end
        // Reset while a result is being held must clear it without waiting for a clock.
        launch(5'd0, 5'd7, 5'd3);
        cycles(5);
        reset = 1'b0;
        #5;
        checks++;
        if (bus.ok !== 1'b0 || bus.A !== '0) begin
            failures++;
            $display("FAIL reset_done: A=%0d ok=%b, want A=0 ok=0", bus.A, bus.ok);
        end
        bus.start = 1'b0;
        cycles(1);
        reset = 1'b1;
        cycles(1);
    endtask

    task automatic test_chained();
        int dividend;
        int divisor;
        logic [W-1:0] q;
        logic [W-1:0] r;
        dividend = 22;
        divisor  = 10;
        q = W'(dividend / divisor);
        r = W'(dividend % divisor);
        launch(q, W'(divisor), r);
        cycles(5);
        checks++;
        if (bus.ok !== 1'b1 || bus.A !== W'(dividend)) begin
            failures++;
            $display("FAIL chained: A=%0d ok=%b, want A=%0d ok=1", bus.A, bus.ok, dividend);
        end
        release_start();
    endtask

    task automatic test_back_to_back();
        launch(5'd5, 5'd6, 5'd1);
        cycles(5);
        checks++;
        if (bus.ok !== 1'b1 || bus.A !== 5'd31) begin
            failures++;
            $display("FAIL b2b_first: A=%0d ok=%b, want A=31 ok=1", bus.A, bus.ok);
        end
        release_start();
        launch(5'd7, 5'd3, 5'd2);
        cycles(5);
        checks++;
        if (bus.ok !== 1'b1 || bus.A !== 5'd23) begin
            failures++;
            $display("FAIL b2b_second: A=%0d ok=%b, want A=23 ok=1", bus.A, bus.ok);
        end
        release_start();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_hold();
        test_zero_quotient();
        test_bad_operands();
        test_overflow_and_max();
        test_reset_abort();
        test_chained();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/remainder_multiply.md
Name: remainder_multiply

Overview:
- Sequential inverse of the divider: reconstructs the dividend as A = Q*B + R from a quotient, divisor and remainder.
- Uses the same clk/reset/start/ok/err handshake style as the divider, so benches can chain divider -> remainder_multiply and compare A against the original dividend.
- Shift-add datapath: one partial product per cycle, W cycles per operation.

Parameters:
- W, 5, operand and result width in bits.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  level request; sampled only in IDLE.
- Q  input  W  quotient operand.
- B  input  W  divisor operand.
- R  input  W  remainder operand.
- A  output  W  reconstructed dividend; valid while ok=1.
- ok  output  1  result valid.
- err  output  1  invalid operands or overflow.

Behaviour:
- Reset (reset=0, asynchronous) forces: state=IDLE, A=0, ok=0, err=0, internal accumulator and counter = 0.
- IDLE: ok=0, err=0.
  - On a clk edge with start=1, capture Q, B and R into registers; this is the capture edge t0.
  - If B==0 or R>=B, go to DONE with err=1, ok=0, A=0. err is visible after t0.
  - Otherwise initialise acc (2W+1 bits) = R, count = 0, and go to RUN.
- RUN: each edge does the following.
  - If Qreg[count]==1, then acc <= acc + (B << count).
  - Increment count.
  - On the edge where count==W-1, go to DONE.
  - RUN occupies exactly W edges (t1..tW).
- DONE entry from RUN:
  - If acc[2W:W] != 0 (overflow), set err=1, ok=0, A=0.
  - Otherwise set ok=1, err=0, A=acc[W-1:0].
  - ok and err are registered, so they are visible right after tW. Latency is W cycles from capture; 500 ns at a 100 ns clock with W=5.
- DONE holds A/ok/err stable until start=0 is sampled. That edge returns to IDLE and clears ok, err and A. This is a four-phase handshake: a start held high never retriggers a second operation.
- Operand inputs may change after t0 without affecting the result.
- Changes on start during RUN are ignored.
- Reset asserted mid-RUN or in DONE aborts immediately to reset values. No result is produced after release until a new start.
- ok and err are never 1 simultaneously.

Decomposition:
- Shared package (divider_pkg):
  - Width constant W=5.
  - State encoding IDLE/RUN/DONE (2 bits).
  - Counter width $clog2(W).
- Single module. The shift-add step is small enough to stay inline; no sub-module.

Test Plan:
- Q=2, B=10, R=2, start=1 after reset release -> ok=1 after 5 cycles, A=22, err=0; holding start=1 keeps A=22 with no restart.
- Q=0, B=7, R=3 -> ok=1, A=3 after 5 cycles; then start=0 -> next edge ok=0, A=0.
- B=0 (Q=4, R=0) -> err=1, ok=0, A=0 one cycle after capture; R=10, B=10 -> same err response.
- Q=31, B=2, R=0 -> err=1 after 5 cycles (62 overflows 5 bits); Q=3, B=10, R=1 -> ok=1, A=31 (max, no err).
- Pull reset low two cycles into RUN -> ok=0, err=0, A=0 immediately (asynchronously); after release with start=0 the block stays in IDLE.
- Chained check: divider on A=22, B=10 gives Q=2, R=2; feeding these in gives A=22, ok=1, matching the original dividend.
